eject_buffer: RTL and testbench



---
 rtl/hoplite_pkg.sv | 27 ++
 rtl/eject_compact.sv | 67 ++++++
 rtl/eject_buffer.sv | 179 +++++++++++++++++
 tb/tb_eject_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hoplite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hoplite_pkg
// Description : Constants shared by the Hoplite router slice: the default
//               flit width, the dimension indices used when ordering the
//               x/y/z eject ports, and the free-slot threshold the ejection
//               buffer must keep before the arbiter may eject again.
// Revision    : 1.0 - initial release
// ============================================================================
package hoplite_pkg;

    // Default flit width in bits.
    localparam int DEFAULT_FLIT_SIZE = 128;

    // Dimension indices. The ordering x -> y -> z is also the priority in
    // which ejected flits are enqueued.
    localparam int DIM_X    = 0;
    localparam int DIM_Y    = 1;
    localparam int DIM_Z    = 2;
    localparam int NUM_DIMS = 3;

    // Worst case one cycle can eject one flit per dimension, so the buffer
    // must hold at least this many free slots to advertise readiness.
    localparam int EJECT_MIN_FREE = 3;

endpackage : hoplite_pkg
`default_nettype wire

// File: rtl/eject_compact.sv
`default_nettype none
// ============================================================================
// Module      : eject_compact
// Description : Purely combinational compaction of the three eject ports.
//               Valid flits are packed into slot_0..slot_2 in x -> y -> z
//               order and their number is reported as count (0..3). Unused
//               slots read as zero.
//
// Ports
//   x_valid / y_valid / z_valid : in  1          per-dimension eject strobe
//   x_flit  / y_flit  / z_flit  : in  FLIT_SIZE  per-dimension eject flit
//   count                       : out 2          number of valid flits
//   slot_0 / slot_1 / slot_2    : out FLIT_SIZE  compacted flits
//
// Revision    : 1.0 - initial release
// ============================================================================
module eject_compact
    import hoplite_pkg::*;
#(
    parameter int FLIT_SIZE = DEFAULT_FLIT_SIZE
) (
    input  logic                 x_valid,
    input  logic                 y_valid,
    input  logic                 z_valid,
    input  logic [FLIT_SIZE-1:0] x_flit,
    input  logic [FLIT_SIZE-1:0] y_flit,
    input  logic [FLIT_SIZE-1:0] z_flit,
    output logic [1:0]           count,
    output logic [FLIT_SIZE-1:0] slot_0,
    output logic [FLIT_SIZE-1:0] slot_1,
    output logic [FLIT_SIZE-1:0] slot_2
);

    logic [NUM_DIMS-1:0] w_valid;
    logic [FLIT_SIZE-1:0] w_flit [NUM_DIMS];
    logic [FLIT_SIZE-1:0] w_slot [NUM_DIMS];
    logic [1:0]           w_k;

    assign w_valid[DIM_X] = x_valid;
    assign w_valid[DIM_Y] = y_valid;
    assign w_valid[DIM_Z] = z_valid;
    assign w_flit[DIM_X]  = x_flit;
    assign w_flit[DIM_Y]  = y_flit;
    assign w_flit[DIM_Z]  = z_flit;

    // Walk the dimensions in priority order; each valid flit takes the next
    // free slot. The running index never exceeds 2 at the point of a write.
    always_comb begin
        w_k = 2'd0;
        for (int s = 0; s < NUM_DIMS; s++) begin
            w_slot[s] = '0;
        end
        for (int d = 0; d < NUM_DIMS; d++) begin
            if (w_valid[d]) begin
                w_slot[w_k] = w_flit[d];
                w_k         = w_k + 2'd1;
            end
        end
    end

    assign count  = w_k;
    assign slot_0 = w_slot[0];
    assign slot_1 = w_slot[1];
    assign slot_2 = w_slot[2];

endmodule : eject_compact
`default_nettype wire

// File: rtl/eject_buffer.sv
`default_nettype none
// ============================================================================
// Module      : eject_buffer
// Description : Ejection buffer between the switch's x/y/z eject outputs and
//               the local PE. Up to three flits per cycle are enqueued in
//               x -> y -> z order into a circular FIFO and drained one per
//               cycle over a valid/ready handshake with first-word
//               fall-through. eject_ready is derived only from the
//               registered fill level, so it has no combinational path from
//               any input and never credits a same-cycle pop.
//
// Ports
//   clk            : in  1                  clock, rising edge
//   rst_n          : in  1                  asynchronous active-low reset
//   x/y/z_eject_valid : in 1 each           eject strobes
//   x/y/z_eject    : in  FLIT_SIZE each     ejected flits
//   eject_ready    : out 1                  free slots >= 3
//   pe_out_valid   : out 1                  head flit available
//   pe_out         : out FLIT_SIZE          head flit (zero when empty)
//   pe_out_ready   : in  1                  PE accepts head
//   occupancy      : out $clog2(DEPTH+1)    current entry count
//   overflow_err   : out 1                  sticky overrun flag
//
// Build option
//   EJECT_BUF_ERR_EN : when defined, overflow_err is a sticky register set
//                      the cycle after any flit is dropped on overrun. When
//                      undefined, overflow_err is tied low; overrun still
//                      drops excess flits in the same way.
//
// Revision    : 1.0 - initial release
// ============================================================================
module eject_buffer
    import hoplite_pkg::*;
#(
    parameter int FLIT_SIZE = DEFAULT_FLIT_SIZE,
    parameter int DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       x_eject_valid,
    input  logic                       y_eject_valid,
    input  logic                       z_eject_valid,
    input  logic [FLIT_SIZE-1:0]       x_eject,
    input  logic [FLIT_SIZE-1:0]       y_eject,
    input  logic [FLIT_SIZE-1:0]       z_eject,
    output logic                       eject_ready,
    output logic                       pe_out_valid,
    output logic [FLIT_SIZE-1:0]       pe_out,
    input  logic                       pe_out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_MIN_FREE = c_CNT_W'(EJECT_MIN_FREE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FLIT_SIZE-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------
    // Compaction of the eject ports
    // ------------------------------------------------------------------
    logic [1:0]           w_k;
    logic [FLIT_SIZE-1:0] w_slot [NUM_DIMS];

    eject_compact #(
        .FLIT_SIZE (FLIT_SIZE)
    ) u_compact (
        .x_valid (x_eject_valid),
        .y_valid (y_eject_valid),
        .z_valid (z_eject_valid),
        .x_flit  (x_eject),
        .y_flit  (y_eject),
        .z_flit  (z_eject),
        .count   (w_k),
        .slot_0  (w_slot[0]),
        .slot_1  (w_slot[1]),
        .slot_2  (w_slot[2])
    );

    // ------------------------------------------------------------------
    // Push / pop bookkeeping
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] w_free;
    logic [c_CNT_W-1:0] w_k_ext;
    logic [c_CNT_W-1:0] w_accept;
    logic               w_drop;
    logic               w_not_empty;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_PTR_W-1:0] w_wr_ptr_next;
    logic [c_PTR_W-1:0] w_rd_ptr_next;

    assign w_free      = c_DEPTH - r_count;
    assign w_k_ext     = c_CNT_W'(w_k);
    // Overrun: only the first w_free compacted flits are kept, which is the
    // x -> y -> z prefix of the push set. A same-cycle pop is not used to
    // make room, matching the conservative ready.
    assign w_drop      = (w_k_ext > w_free);
    assign w_accept    = w_drop ? w_free : w_k_ext;
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty & pe_out_ready;

    assign w_count_next  = r_count + w_accept - c_CNT_W'(w_pop);
    // w_accept is at most 3 and DEPTH >= 4, so the narrowing cast is exact;
    // pointer arithmetic wraps modulo DEPTH because DEPTH is a power of two.
    assign w_wr_ptr_next = r_wr_ptr + c_PTR_W'(w_accept);
    assign w_rd_ptr_next = r_rd_ptr + c_PTR_W'(w_pop);

    // Per-slot write address; a push straddling the top of the array splits
    // naturally across the last and first entries.
    logic [c_PTR_W-1:0] w_wr_addr [NUM_DIMS];

    for (genvar g = 0; g < NUM_DIMS; g++) begin : g_wr_addr
        assign w_wr_addr[g] = r_wr_ptr + c_PTR_W'(g);
    end

    // ------------------------------------------------------------------
    // Storage: not reset, only written for accepted slots
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_DIMS; j++) begin
            if (c_CNT_W'(j) < w_accept) begin
                r_mem[w_wr_addr[j]] <= w_slot[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and fill level
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign occupancy    = r_count;
    assign pe_out_valid = w_not_empty;
    // Gated so the head reads zero out of reset and whenever the FIFO is
    // empty, independent of stale storage contents.
    assign pe_out       = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign eject_ready  = (w_free >= c_MIN_FREE);

`ifdef EJECT_BUF_ERR_EN
    logic r_overflow_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow_err <= 1'b0;
        end else if (w_drop) begin
            r_overflow_err <= 1'b1;
        end
    end

    assign overflow_err = r_overflow_err;
`else
    assign overflow_err = 1'b0;
`endif

endmodule : eject_buffer
`default_nettype wire

// File: tb/tb_eject_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_eject_buffer
// Description : Directed self-checking bench for eject_buffer (DEPTH = 8,
//               FLIT_SIZE = 128). A table of per-cycle stimulus with the
//               expected pre-edge outputs, followed by hand-written
//               sequences for wrap, overrun, push+pop, empty pop and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eject_buffer;

    localparam int FW    = 128;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef EJECT_BUF_ERR_EN
    localparam logic c_EXP_OVF = 1'b1;
`else
    localparam logic c_EXP_OVF = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          x_eject_valid, y_eject_valid, z_eject_valid;
    logic [FW-1:0] x_eject, y_eject, z_eject;
    logic          eject_ready;
    logic          pe_out_valid;
    logic [FW-1:0] pe_out;
    logic          pe_out_ready;
    logic [CW-1:0] occupancy;
    logic          overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    eject_buffer #(
        .FLIT_SIZE (FW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .x_eject_valid (x_eject_valid),
        .y_eject_valid (y_eject_valid),
        .z_eject_valid (z_eject_valid),
        .x_eject       (x_eject),
        .y_eject       (y_eject),
        .z_eject       (z_eject),
        .eject_ready   (eject_ready),
        .pe_out_valid  (pe_out_valid),
        .pe_out        (pe_out),
        .pe_out_ready  (pe_out_ready),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          xv, yv, zv;
        logic [FW-1:0] x, y, z;
        logic          rdy;
        logic          ev;
        logic [FW-1:0] eo;
        logic [CW-1:0] eocc;
        logic          er;
    } vec_t;

    function automatic vec_t mk(input logic xv, input logic yv, input logic zv,
                                input int x, input int y, input int z,
                                input logic rdy, input logic ev, input int eo,
                                input int eocc, input logic er);
        vec_t v;
        v.xv = xv; v.yv = yv; v.zv = zv;
        v.x = FW'(x); v.y = FW'(y); v.z = FW'(z);
        v.rdy = rdy; v.ev = ev; v.eo = FW'(eo);
        v.eocc = CW'(eocc); v.er = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act,
                         input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic xv, input logic yv, input logic zv,
                         input int x, input int y, input int z, input logic rdy);
        x_eject_valid = xv; y_eject_valid = yv; z_eject_valid = zv;
        x_eject = FW'(x); y_eject = FW'(y); z_eject = FW'(z);
        pe_out_ready = rdy;
    endtask

    task automatic check_state(input string tag, input logic ev, input int eo,
                               input int eocc, input logic er);
        check({tag, ".valid"}, FW'(pe_out_valid), FW'(ev));
        check({tag, ".pe_out"}, pe_out, FW'(eo));
        check({tag, ".occupancy"}, FW'(occupancy), FW'(eocc));
        check({tag, ".eject_ready"}, FW'(eject_ready), FW'(er));
    endtask

    vec_t vecs[16];
    int   drain_exp[8];

    initial begin
        // Each row: stimulus for this cycle, and outputs expected before the
        // rising edge that samples it (i.e. the state left by earlier rows).
        //             xv yv zv  x       y     z     rdy  ev  eo    occ er
        vecs[0]  = mk(0, 0, 0, 'hFFFF, 'hEE, 'hDD, 1,   0, 0,     0,  1);
        vecs[1]  = mk(1, 1, 1, 'hA,    'hB,  'hC,  1,   0, 0,     0,  1);
        vecs[2]  = mk(0, 0, 0, 0,      0,    0,    1,   1, 'hA,   3,  1);
        vecs[3]  = mk(0, 0, 0, 0,      0,    0,    1,   1, 'hB,   2,  1);
        vecs[4]  = mk(0, 0, 0, 0,      0,    0,    1,   1, 'hC,   1,  1);
        vecs[5]  = mk(0, 1, 1, 'h99,   'h5,  'h6,  0,   0, 0,     0,  1);
        vecs[6]  = mk(0, 0, 0, 'hDEAD, 'h77, 'h88, 0,   1, 'h5,   2,  1);
        vecs[7]  = mk(1, 1, 0, 'h11,   'h12, 'h55, 0,   1, 'h5,   2,  1);
        vecs[8]  = mk(1, 1, 0, 'h13,   'h14, 'h66, 0,   1, 'h5,   4,  1);
        vecs[9]  = mk(0, 0, 0, 0,      0,    0,    1,   1, 'h5,   6,  0);
        vecs[10] = mk(0, 0, 0, 0,      0,    0,    1,   1, 'h6,   5,  1);
        vecs[11] = mk(0, 0, 0, 0,      0,    0,    1,   1, 'h11,  4,  1);
        vecs[12] = mk(0, 0, 0, 0,      0,    0,    1,   1, 'h12,  3,  1);
        vecs[13] = mk(0, 0, 0, 0,      0,    0,    1,   1, 'h13,  2,  1);
        vecs[14] = mk(0, 0, 0, 0,      0,    0,    1,   1, 'h14,  1,  1);
        vecs[15] = mk(0, 0, 0, 0,      0,    0,    1,   0, 0,     0,  1);

        drain_exp = '{'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h31};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset values while reset is held.
        check_state("reset", 0, 0, 0, 1);
        check("reset.overflow_err", FW'(overflow_err), FW'(1'b0));
        rst_n = 1'b1;

        // Table-driven section. After it, wr_ptr = rd_ptr = 1, empty.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_state($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].eo),
                        int'(vecs[i].eocc), vecs[i].er);
            drive(vecs[i].xv, vecs[i].yv, vecs[i].zv, int'(vecs[i].x),
                  int'(vecs[i].y), int'(vecs[i].z), vecs[i].rdy);
        end

        // Advance wr_ptr to 6 with five flits, PE stalled.
        @(negedge clk);
        drive(1, 1, 1, 'h21, 'h22, 'h23, 0);
        @(negedge clk);
        check("fill.occ3", FW'(occupancy), FW'(3));
        drive(1, 1, 0, 'h24, 'h25, 0, 0);

        // Count 5: push three (landing in 6, 7, 0) and pop one together.
        @(negedge clk);
        check_state("pushpop.pre", 1, 'h21, 5, 1);
        drive(1, 1, 1, 'h26, 'h27, 'h28, 1);

        // Count 7: push three with PE stalled -> only x accepted.
        @(negedge clk);
        check_state("pushpop.post", 1, 'h22, 7, 0);
        check("pushpop.no_err", FW'(overflow_err), FW'(1'b0));
        drive(1, 1, 1, 'h31, 'h32, 'h33, 0);

        @(negedge clk);
        check_state("overrun", 1, 'h22, 8, 0);
        check("overrun.overflow_err", FW'(overflow_err), FW'(c_EXP_OVF));
        drive(0, 0, 0, 0, 0, 0, 1);

        // Drain across the wrap; order must be preserved, y/z of the
        // overrun push must not appear.
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d.pe_out", i), pe_out, FW'(drain_exp[i]));
            check($sformatf("drain%0d.occ", i), FW'(occupancy), FW'(8 - i));
            @(negedge clk);
        end
        check_state("drained", 0, 0, 0, 1);

        // Pop request on an empty buffer is ignored.
        @(negedge clk);
        check_state("empty_pop", 0, 0, 0, 1);
        check("sticky.overflow_err", FW'(overflow_err), FW'(c_EXP_OVF));

        // Reset asserted mid-drain clears everything asynchronously.
        drive(1, 1, 1, 'h41, 'h42, 'h43, 1);
        @(negedge clk);
        check_state("rst_burst0", 1, 'h41, 3, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check_state("rst_burst1", 1, 'h42, 2, 1);
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 0, 0, 0, 1);
        check("async_rst.overflow_err", FW'(overflow_err), FW'(1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("post_rst", 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_eject_buffer
`default_nettype wire
